dragon_motion_ctrl: RTL and testbench

//  Consumer end of the Dragon_clk / Dragon_speedup pair. Synchronises the slow Dragon_clk square wave into clk domain,

---
 rtl/dragon_pkg.sv | 33 +++
 rtl/dragon_clk_edge_sync.sv | 39 +++
 rtl/dragon_motion_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_dragon_motion_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dragon_pkg.sv
// Shared types for the dragon sprite motion controller: coordinate widths,
// FSM state encoding and default screen limits.
package dragon_pkg;

    localparam int COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;
    // One extra bit so right-edge sums cannot wrap before the compare.
    typedef logic [COORD_W:0]   coord_ext_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MOVE_R = 3'd1,
        ST_MOVE_L = 3'd2,
        ST_DROP   = 3'd3,
        ST_LANDED = 3'd4
    } dragon_state_e;

    localparam int unsigned DEF_X_MIN           = 16;
    localparam int unsigned DEF_X_MAX           = 600;
    localparam int unsigned DEF_X_START         = 16;
    localparam int unsigned DEF_Y_MIN           = 32;
    localparam int unsigned DEF_Y_MAX           = 400;
    localparam int unsigned DEF_X_STEP          = 8;
    localparam int unsigned DEF_Y_STEP          = 16;
    localparam int unsigned DEF_SPEEDUP_BOUNCES = 4;
    localparam int unsigned DEF_WDOG_CYCLES     = 50_000_000;

    function automatic coord_ext_t ext(input coord_t c);
        return {1'b0, c};
    endfunction

endpackage

// File: rtl/dragon_clk_edge_sync.sv
// Brings the asynchronous Dragon_clk square wave into the clk domain and
// emits a registered one-cycle pulse for every rising edge.
module dragon_clk_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic step_pulse
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;
    logic pulse_q, pulse_d;

    // s1/s2 form the synchroniser; s3 is the history used for edge detection.
    always_comb begin
        s1_d    = async_in;
        s2_d    = s1_q;
        s3_d    = s2_q;
        pulse_d = s2_q & ~s3_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            pulse_q <= pulse_d;
        end
    end

    assign step_pulse = pulse_q;

endmodule

// File: rtl/dragon_motion_ctrl.sv
// Dragon sprite motion: bounces left/right, drops a row at each wall, lands at
// the bottom and requests a speed-up. Optional stall watchdog: DRAGON_WDOG_EN.
module dragon_motion_ctrl
    import dragon_pkg::*;
#(
    parameter int unsigned X_MIN           = DEF_X_MIN,
    parameter int unsigned X_MAX           = DEF_X_MAX,
    parameter int unsigned X_START         = DEF_X_START,
    parameter int unsigned Y_MIN           = DEF_Y_MIN,
    parameter int unsigned Y_MAX           = DEF_Y_MAX,
    parameter int unsigned X_STEP          = DEF_X_STEP,
    parameter int unsigned Y_STEP          = DEF_Y_STEP,
    parameter int unsigned SPEEDUP_BOUNCES = DEF_SPEEDUP_BOUNCES,
    parameter int unsigned WDOG_CYCLES     = DEF_WDOG_CYCLES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          Dragon_clk,
    input  logic          enable,
    output logic          Dragon_speedup,
    output coord_t        dragon_x,
    output coord_t        dragon_y,
    output logic          dragon_dir,
    output logic          step_pulse,
    output logic          dragon_landed,
    output logic          dragon_clk_stall,
    output dragon_state_e dbg_state
);

    localparam coord_t     X_MIN_C   = coord_t'(X_MIN);
    localparam coord_t     X_MAX_C   = coord_t'(X_MAX);
    localparam coord_t     X_START_C = coord_t'(X_START);
    localparam coord_t     Y_MIN_C   = coord_t'(Y_MIN);
    localparam coord_t     Y_MAX_C   = coord_t'(Y_MAX);
    localparam coord_t     X_STEP_C  = coord_t'(X_STEP);
    localparam coord_ext_t X_MAX_E   = coord_ext_t'(X_MAX);
    localparam coord_ext_t X_STEP_E  = coord_ext_t'(X_STEP);
    localparam coord_ext_t X_LEFT_E  = coord_ext_t'(X_MIN + X_STEP);
    localparam coord_ext_t Y_MAX_E   = coord_ext_t'(Y_MAX);
    localparam coord_ext_t Y_STEP_E  = coord_ext_t'(Y_STEP);
    localparam logic [7:0] SPEEDUP_TH = 8'(SPEEDUP_BOUNCES);

    dragon_state_e state_q, state_d;
    coord_t        x_q, x_d;
    coord_t        y_q, y_d;
    logic          dir_q, dir_d;
    logic          next_dir_q, next_dir_d;
    logic [7:0]    bounce_q, bounce_d;
    logic          speedup_q, speedup_d;
    logic          landed_q, landed_d;

    logic          step;
    logic          step_go;
    coord_ext_t    x_right;
    coord_ext_t    y_sum;

    dragon_clk_edge_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .async_in   (Dragon_clk),
        .step_pulse (step)
    );

    assign step_go = step & enable;
    assign x_right = ext(x_q) + X_STEP_E;
    assign y_sum   = ext(y_q) + Y_STEP_E;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        dir_d      = dir_q;
        next_dir_d = next_dir_q;
        bounce_d   = bounce_q;
        landed_d   = landed_q;
        speedup_d  = speedup_q | (bounce_q >= SPEEDUP_TH);

        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_MOVE_R;
            end
            ST_MOVE_R: begin
                if (step_go) begin
                    if (x_right > X_MAX_E) begin
                        x_d        = X_MAX_C;
                        next_dir_d = 1'b1;
                        state_d    = ST_DROP;
                    end else begin
                        x_d = x_right[COORD_W-1:0];
                    end
                end
            end
            ST_MOVE_L: begin
                if (step_go) begin
                    if (ext(x_q) < X_LEFT_E) begin
                        x_d        = X_MIN_C;
                        next_dir_d = 1'b0;
                        state_d    = ST_DROP;
                    end else begin
                        x_d = x_q - X_STEP_C;
                    end
                end
            end
            ST_DROP: begin
                if (step_go) begin
                    y_d   = (y_sum >= Y_MAX_E) ? Y_MAX_C : y_sum[COORD_W-1:0];
                    dir_d = next_dir_q;
                    if (bounce_q != 8'hFF) bounce_d = bounce_q + 8'd1;
                    if (y_d == Y_MAX_C) begin
                        landed_d = 1'b1;
                        state_d  = ST_LANDED;
                    end else begin
                        state_d = next_dir_q ? ST_MOVE_L : ST_MOVE_R;
                    end
                end
            end
            ST_LANDED: begin
                state_d = ST_LANDED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            x_q        <= X_START_C;
            y_q        <= Y_MIN_C;
            dir_q      <= 1'b0;
            next_dir_q <= 1'b0;
            bounce_q   <= 8'd0;
            speedup_q  <= 1'b0;
            landed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            dir_q      <= dir_d;
            next_dir_q <= next_dir_d;
            bounce_q   <= bounce_d;
            speedup_q  <= speedup_d;
            landed_q   <= landed_d;
        end
    end

`ifdef DRAGON_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES) + 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              stall_q, stall_d;

    // A frozen game is not a stalled divider, so enable=0 also clears the count.
    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        stall_d    = stall_q;
        if (step || !enable) begin
            wdog_cnt_d = '0;
        end else if (wdog_cnt_q != WDOG_LAST) begin
            wdog_cnt_d = wdog_cnt_q + 1'b1;
        end
        if (step) begin
            stall_d = 1'b0;
        end else if (wdog_cnt_q == WDOG_LAST) begin
            stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt_q <= '0;
            stall_q    <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            stall_q    <= stall_d;
        end
    end

    assign dragon_clk_stall = stall_q;
`else
    logic unused_wdog;
    assign unused_wdog      = ^WDOG_CYCLES;
    assign dragon_clk_stall = 1'b0;
`endif

    assign Dragon_speedup = speedup_q;
    assign dragon_x       = x_q;
    assign dragon_y       = y_q;
    assign dragon_dir     = dir_q;
    assign step_pulse     = step;
    assign dragon_landed  = landed_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_dragon_motion_ctrl.sv
// Self-checking bench for dragon_motion_ctrl: a behavioural sprite model pushes
// expected {landed,dir,y,x} per Dragon_clk edge; popped one cycle after step_pulse.
module tb_dragon_motion_ctrl;
    import dragon_pkg::*;

    logic          clk;
    logic          rst;
    logic          Dragon_clk;
    logic          enable;
    logic          Dragon_speedup;
    coord_t        dragon_x;
    coord_t        dragon_y;
    logic          dragon_dir;
    logic          step_pulse;
    logic          dragon_landed;
    logic          dragon_clk_stall;
    dragon_state_e dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [21:0] exp_q[$];

    // Behavioural model of the sprite
    localparam int M_IDLE = 0, M_R = 1, M_L = 2, M_DROP = 3, M_LANDED = 4;
    int m_x, m_y, m_dir, m_ndir, m_state, m_bounce, m_landed;

    dragon_motion_ctrl #(.WDOG_CYCLES(100)) dut (
        .clk              (clk),
        .rst              (rst),
        .Dragon_clk       (Dragon_clk),
        .enable           (enable),
        .Dragon_speedup   (Dragon_speedup),
        .dragon_x         (dragon_x),
        .dragon_y         (dragon_y),
        .dragon_dir       (dragon_dir),
        .step_pulse       (step_pulse),
        .dragon_landed    (dragon_landed),
        .dragon_clk_stall (dragon_clk_stall),
        .dbg_state        (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 3ms");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        m_x = 16; m_y = 32; m_dir = 0; m_ndir = 0;
        m_state = M_IDLE; m_bounce = 0; m_landed = 0;
    endtask

    task automatic model_step();
        if (!enable) return;
        case (m_state)
            M_R: begin
                if (m_x + 8 > 600) begin m_x = 600; m_ndir = 1; m_state = M_DROP; end
                else m_x = m_x + 8;
            end
            M_L: begin
                if (m_x < 16 + 8) begin m_x = 16; m_ndir = 0; m_state = M_DROP; end
                else m_x = m_x - 8;
            end
            M_DROP: begin
                m_y = (m_y + 16 > 400) ? 400 : m_y + 16;
                if (m_bounce < 255) m_bounce = m_bounce + 1;
                m_dir = m_ndir;
                if (m_y == 400) begin m_landed = 1; m_state = M_LANDED; end
                else m_state = (m_ndir == 1) ? M_L : M_R;
            end
            default: ;
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        Dragon_clk = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic go_enable();
        enable = 1'b1;
        repeat (2) @(negedge clk);
        if (m_state == M_IDLE) m_state = M_R;
    endtask

    // Driver: one Dragon_clk period (hi then lo clk cycles); scoreboard pop after the pulse.
    task automatic drive_edge(input int hi, input int lo, output int first_c);
        logic [21:0] exp_v, got_v;
        bit prev;
        int pulses;
        model_step();
        exp_q.push_back({m_landed[0], m_dir[0], 10'(m_y), 10'(m_x)});
        Dragon_clk = 1'b1;
        pulses = 0;
        first_c = -1;
        prev = 1'b0;
        for (int c = 0; c < hi + lo; c++) begin
            @(negedge clk);
            if (prev && exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                got_v = {dragon_landed, dragon_dir, dragon_y, dragon_x};
                n_tests++;
                if (got_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL step_state: got x=%0d y=%0d dir=%0d landed=%0d, expected x=%0d y=%0d dir=%0d landed=%0d",
                             got_v[9:0], got_v[19:10], got_v[20], got_v[21],
                             exp_v[9:0], exp_v[19:10], exp_v[20], exp_v[21]);
                end
            end
            prev = step_pulse;
            if (step_pulse) begin
                pulses++;
                if (first_c < 0) first_c = c;
            end
            if (c == hi - 1) Dragon_clk = 1'b0;
        end
        if (exp_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL step_timeout: no step_pulse within %0d cycles, required one", hi + lo);
            exp_q.delete();
        end
        n_tests++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL pulse_count: got %0d pulses, expected 1", pulses);
        end
        n_tests++;
        if (Dragon_speedup !== (m_bounce >= 4)) begin
            n_fail++;
            $display("FAIL speedup: got %0b, expected %0b (bounces=%0d)", Dragon_speedup, (m_bounce >= 4), m_bounce);
        end
    endtask

    task automatic test_reset();
        int fc;
        enable = 1'b0;
        do_reset();
        @(negedge clk);
        n_tests++; if (dragon_x !== 10'd16) begin n_fail++; $display("FAIL reset_x: got %0d, expected 16", dragon_x); end
        n_tests++; if (dragon_y !== 10'd32) begin n_fail++; $display("FAIL reset_y: got %0d, expected 32", dragon_y); end
        n_tests++; if (dragon_dir !== 1'b0) begin n_fail++; $display("FAIL reset_dir: got %0b, expected 0", dragon_dir); end
        n_tests++; if (Dragon_speedup !== 1'b0) begin n_fail++; $display("FAIL reset_speedup: got %0b, expected 0", Dragon_speedup); end
        n_tests++; if (dragon_landed !== 1'b0) begin n_fail++; $display("FAIL reset_landed: got %0b, expected 0", dragon_landed); end
        n_tests++; if (step_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_step: got %0b, expected 0", step_pulse); end
        n_tests++; if (dragon_clk_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b, expected 0", dragon_clk_stall); end
        n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d, expected %0d", dbg_state, ST_IDLE); end
        // Disabled in IDLE: edge still pulses but nothing moves.
        drive_edge(4, 4, fc);
    endtask

    task automatic test_first_steps();
        int fc;
        go_enable();
        for (int i = 0; i < 2; i++) begin
            drive_edge(32, 32, fc);
            n_tests++;
            if (fc !== 2) begin n_fail++; $display("FAIL step_latency: pulse at negedge %0d after rise, expected 2", fc); end
        end
        n_tests++;
        if (dragon_x !== 10'd32 || dragon_y !== 10'd32 || dragon_dir !== 1'b0) begin
            n_fail++;
            $display("FAIL first_steps: got x=%0d y=%0d dir=%0b, expected x=32 y=32 dir=0", dragon_x, dragon_y, dragon_dir);
        end
    endtask

    task automatic test_right_edge();
        int fc, g;
        g = 0;
        while (m_x != 592 && g < 200) begin drive_edge(4, 4, fc); g++; end
        drive_edge(4, 4, fc);
        n_tests++; if (dragon_x !== 10'd600) begin n_fail++; $display("FAIL right_clamp: got x=%0d, expected 600", dragon_x); end
        drive_edge(4, 4, fc);
        n_tests++; if (dragon_x !== 10'd600) begin n_fail++; $display("FAIL right_hold: got x=%0d, expected 600", dragon_x); end
        drive_edge(4, 4, fc);
        n_tests++;
        if (dragon_y !== 10'd48 || dragon_dir !== 1'b1) begin
            n_fail++; $display("FAIL first_drop: got y=%0d dir=%0b, expected y=48 dir=1", dragon_y, dragon_dir);
        end
        drive_edge(4, 4, fc);
        n_tests++; if (dragon_x !== 10'd592) begin n_fail++; $display("FAIL move_left: got x=%0d, expected 592", dragon_x); end
    endtask

    task automatic test_held_high_and_fast();
        int fc;
        drive_edge(1000, 8, fc);
        for (int i = 0; i < 6; i++) drive_edge(2, 3, fc);
    endtask

    task automatic test_enable_hold();
        int fc;
        coord_t hx, hy;
        enable = 1'b0;
        hx = dragon_x;
        hy = dragon_y;
        for (int i = 0; i < 3; i++) drive_edge(4, 4, fc);
        n_tests++;
        if (dragon_x !== hx || dragon_y !== hy) begin
            n_fail++; $display("FAIL enable_hold: got x=%0d y=%0d, expected x=%0d y=%0d", dragon_x, dragon_y, hx, hy);
        end
        enable = 1'b1;
        for (int i = 0; i < 2; i++) drive_edge(4, 4, fc);
    endtask

    task automatic test_bounces_landing();
        int fc, g;
        bit seen3, seen4;
        g = 0; seen3 = 0; seen4 = 0;
        while (!m_landed && g < 3000) begin
            drive_edge(4, 4, fc);
            g++;
            if (m_bounce == 3 && !seen3) begin
                seen3 = 1; n_tests++;
                if (Dragon_speedup !== 1'b0) begin n_fail++; $display("FAIL speedup_3rd: got %0b, expected 0", Dragon_speedup); end
            end
            if (m_bounce == 4 && !seen4) begin
                seen4 = 1; n_tests++;
                if (Dragon_speedup !== 1'b1) begin n_fail++; $display("FAIL speedup_4th: got %0b, expected 1", Dragon_speedup); end
            end
        end
        n_tests++;
        if (dragon_landed !== 1'b1 || dragon_y !== 10'd400) begin
            n_fail++; $display("FAIL landing: got landed=%0b y=%0d, expected landed=1 y=400", dragon_landed, dragon_y);
        end
        for (int i = 0; i < 3; i++) drive_edge(4, 4, fc);
        n_tests++; if (dbg_state !== ST_LANDED) begin n_fail++; $display("FAIL landed_state: got %0d, expected %0d", dbg_state, ST_LANDED); end
    endtask

    task automatic pulse_rst_and_check(input string tag);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_tests++;
        if (dragon_x !== 10'd16 || dragon_y !== 10'd32 || Dragon_speedup !== 1'b0 || dragon_landed !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got x=%0d y=%0d speedup=%0b landed=%0b, expected x=16 y=32 speedup=0 landed=0",
                     tag, dragon_x, dragon_y, Dragon_speedup, dragon_landed);
        end
    endtask

    task automatic test_reset_mid_drop();
        int fc, g;
        pulse_rst_and_check("reset_after_landed");
        go_enable();
        g = 0;
        while (m_state != M_DROP && g < 200) begin drive_edge(4, 4, fc); g++; end
        n_tests++; if (dbg_state !== ST_DROP) begin n_fail++; $display("FAIL reach_drop: got %0d, expected %0d", dbg_state, ST_DROP); end
        pulse_rst_and_check("reset_mid_drop");
        go_enable();
        drive_edge(4, 4, fc);
    endtask

    task automatic test_watchdog();
        int fc;
        do_reset();
        go_enable();
`ifdef DRAGON_WDOG_EN
        repeat (48) @(negedge clk);
        n_tests++; if (dragon_clk_stall !== 1'b0) begin n_fail++; $display("FAIL wdog_early: got %0b, expected 0", dragon_clk_stall); end
        repeat (70) @(negedge clk);
        n_tests++; if (dragon_clk_stall !== 1'b1) begin n_fail++; $display("FAIL wdog_stall: got %0b, expected 1", dragon_clk_stall); end
        drive_edge(4, 4, fc);
        n_tests++; if (dragon_clk_stall !== 1'b0) begin n_fail++; $display("FAIL wdog_clear: got %0b, expected 0", dragon_clk_stall); end
`else
        repeat (150) @(negedge clk);
        n_tests++; if (dragon_clk_stall !== 1'b0) begin n_fail++; $display("FAIL wdog_off: got %0b, expected 0", dragon_clk_stall); end
        drive_edge(4, 4, fc);
`endif
    endtask

    initial begin
        rst = 1'b1;
        Dragon_clk = 1'b0;
        enable = 1'b0;
        model_reset();
        test_reset();
        test_first_steps();
        test_right_edge();
        test_held_high_and_fast();
        test_enable_hold();
        test_bounces_landing();
        test_reset_mid_drop();
        test_watchdog();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
